stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//  Run-control stage directly upstream of the BCD digit counter in the 4-digit stopwatch.
//  Synchronises and debounces two raw push-buttons: start/stop and lap/clear.
//  Runs a run/stop/lap/clear state machine and drives the counter's count-enable and clear.
//  Drives the display path's lap-hold. Sits in the 100 Hz clk_frq domain.
// PARAMETERS
//  DB_CNT  3  consecutive differing synced samples needed to flip a debounced level (>=1; 3 = 30 ms)
// PORTS
//  clk_frq    in   1  100 Hz system tick clock, all state on rising edge
//  rst        in   1  reset, asynchronous, active-high
//  btn_ss     in   1  raw start/stop button, async to clk_frq, active-high
//  btn_lap    in   1  raw lap/clear button, async to clk_frq, active-high
//  ovf        in   1  carry-out of most significant counter digit (9999 -> 0000), one cycle
//  cnt_en     out  1  counter increment enable (level)
//  cnt_clr    out  1  synchronous counter clear, one-cycle pulse
//  disp_hold  out  1  freeze displayed value (lap), level
//  state      out  3  current FSM state, for debug LEDs
// BEHAVIOUR
//  Reset: all flops 0. State IDLE. cnt_en=0, cnt_clr=0, disp_hold=0, state=3'd0.
//    Debounced levels=0. Debounce counters=0.
//  Synchroniser: 2 FFs per button (s1, s2). No logic between them.
//  Debounce, per button, on s2 vs debounced level db:
//    s2==db -> counter cleared.
//    s2!=db and counter==DB_CNT-1 -> db flips, counter cleared.
//    s2!=db otherwise -> counter+1.
//    Counter width $clog2(DB_CNT+1). Glitches shorter than DB_CNT samples never flip db.
//  Press pulse: registered, high for exactly one cycle on each db 0->1. No pulse on release.
//  Latency: raw rise before edge 1 gives db=1 at edge 2+DB_CNT and press high after edge 3+DB_CNT.
//    FSM state/outputs update at edge 4+DB_CNT (edge 7 = 70 ms for the default).
//  Button held through reset release: treated as a fresh press (db starts at 0).
//  FSM (Moore; outputs decoded from registered state):
//    IDLE=0: ss -> RUN. lap ignored.
//    RUN=1:  ovf -> STOP. else ss -> STOP. else lap -> LAP.
//    LAP=2:  ovf -> STOP. else ss -> STOP (hold released). else lap -> RUN.
//    STOP=3: ss -> RUN. else lap -> CLR.
//    CLR=4:  unconditional -> IDLE after one cycle.
//    Codes 5..7: -> IDLE next edge, outputs as IDLE.
//  Outputs:
//    cnt_en = (RUN|LAP).
//    disp_hold = LAP.
//    cnt_clr = CLR (exactly one cycle).
//    state = state register.
//  Simultaneous events:
//    ovf beats ss, ss beats lap.
//    A losing press is dropped, never queued.
//  ovf outside RUN/LAP: ignored.
//  Overflow halts the count at the wrapped value in STOP.
//  Async rst mid-run: state->IDLE immediately. The counter is cleared by its own rst, not by cnt_clr.
// STRUCTURE
//  Shared header sw_defs.vh: FSM state localparams (IDLE..CLR) and state width.
//    Shared with the display/debug logic.
//  Sub-module btn_debounce: sync + debounce + press pulse, param DB_CNT.
//    Ports clk_frq, rst, btn_raw, btn_press. Instantiated twice.
//  Top of this block: two btn_debounce instances plus the FSM and output decode.
// TESTING (DB_CNT=3; "press" = hold raw high >=8 cycles)
//  1. Reset, press btn_ss -> state IDLE->RUN at edge 7, cnt_en=1, cnt_clr=0, disp_hold=0.
//  2. RUN: 2-cycle glitch on btn_ss -> no state change.
//     Then press btn_lap -> LAP, disp_hold=1, cnt_en stays 1.
//     Press btn_lap again -> RUN, disp_hold=0.
//  3. RUN: press btn_ss -> STOP, cnt_en=0.
//     Press btn_lap -> CLR with cnt_clr high exactly 1 cycle, then IDLE.
//  4. RUN: pulse ovf for 1 cycle in the same cycle as a btn_ss press pulse -> STOP, not RUN.
//     The ss press is dropped: state stays STOP for 20 more cycles.
//  5. STOP: btn_ss and btn_lap rise on the same edge -> RUN. No CLR, no cnt_clr pulse.
//  6. LAP: assert rst for 1 cycle mid-count -> all outputs 0 asynchronously, state=0.
//     btn_ss held through reset release -> RUN 7 edges after release.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared run-control definitions: FSM state encoding and width, also used by
// the display/debug logic.
package stopwatch_ctrl_pkg;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 3'd0,
      RUN  = 3'd1,
      LAP  = 3'd2,
      STOP = 3'd3,
      CLR  = 3'd4
   } sw_state_e;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Two-flop synchroniser, counting debouncer and one-cycle press pulse for one
// raw push-button.
module btn_debounce #(
   parameter int unsigned DB_CNT = 3
) (
   input  logic clk_frq,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_press
);

   localparam int unsigned CW = $clog2(DB_CNT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

   logic          s1;
   logic          s2;
   logic          db;
   logic          db_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk_frq or posedge rst) begin
      if (rst) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         db        <= 1'b0;
         db_d      <= 1'b0;
         cnt       <= '0;
         btn_press <= 1'b0;
      end else begin
         s1        <= btn_raw;
         s2        <= s1;
         db_d      <= db;
         btn_press <= db & ~db_d;
         // Any sample agreeing with db restarts the run, so short glitches never flip it
         if (s2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            db  <= ~db;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run control: debounced start/stop and lap/clear buttons driving a
// Moore run/stop/lap/clear FSM that enables, clears and freezes the BCD counter.
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int unsigned DB_CNT = 3
) (
   input  logic               clk_frq,
   input  logic               rst,
   input  logic               btn_ss,
   input  logic               btn_lap,
   input  logic               ovf,
   output logic               cnt_en,
   output logic               cnt_clr,
   output logic               disp_hold,
   output logic [STATE_W-1:0] state
);

   logic      ss_press;
   logic      lap_press;
   sw_state_e state_q;
   sw_state_e state_d;

   btn_debounce #(.DB_CNT(DB_CNT)) u_db_ss (
      .clk_frq   (clk_frq),
      .rst       (rst),
      .btn_raw   (btn_ss),
      .btn_press (ss_press)
   );

   btn_debounce #(.DB_CNT(DB_CNT)) u_db_lap (
      .clk_frq   (clk_frq),
      .rst       (rst),
      .btn_raw   (btn_lap),
      .btn_press (lap_press)
   );

   always_ff @(posedge clk_frq or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Priority ovf > ss > lap; a losing press is simply dropped
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (ss_press) state_d = RUN;
         RUN: begin
            if (ovf)            state_d = STOP;
            else if (ss_press)  state_d = STOP;
            else if (lap_press) state_d = LAP;
         end
         LAP: begin
            if (ovf)            state_d = STOP;
            else if (ss_press)  state_d = STOP;
            else if (lap_press) state_d = RUN;
         end
         STOP: begin
            if (ss_press)       state_d = RUN;
            else if (lap_press) state_d = CLR;
         end
         CLR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_en    = 1'b0;
      cnt_clr   = 1'b0;
      disp_hold = 1'b0;
      case (state_q)
         RUN: cnt_en = 1'b1;
         LAP: begin
            cnt_en    = 1'b1;
            disp_hold = 1'b1;
         end
         CLR:     cnt_clr = 1'b1;
         default: ;
      endcase
   end

   assign state = state_q;

endmodule
